// File: rtl/alu_pkg.sv
// Shared constants and the issue-entry type for the ALU decode-and-issue stage.
package alu_pkg;

  localparam int XLEN    = 32;
  localparam int NUM_OPS = 10;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_XOR  = 2;
  localparam int OP_OR   = 3;
  localparam int OP_AND  = 4;
  localparam int OP_SLL  = 5;
  localparam int OP_SLTU = 6;
  localparam int OP_SRL  = 7;
  localparam int OP_SRA  = 8;
  localparam int OP_SLT  = 9;

  typedef struct packed {
    logic [NUM_OPS-1:0] op_en;
    logic [XLEN-1:0]    rs1;
    logic [XLEN-1:0]    rs2;
    logic [4:0]         rd;
    logic               illegal;
  } issue_t;

endpackage

// File: rtl/alu_op_dec.sv
// Combinational RV32I ALU decoder: instruction -> one-hot op enable, operand B, illegal.
// Build macro ALU_ITYPE_EN adds decoding of opcode 0010011 with immediate operand B.
module alu_op_dec
  import alu_pkg::*;
(
  input  logic [31:0]        instr,
  input  logic [31:0]        rs2_data,
  output logic [NUM_OPS-1:0] op_en,
  output logic [31:0]        opb,
  output logic               illegal
);

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic               is_r;
  logic               is_i;
  logic               f7_base;
  logic               f7_alt;
  logic               f7_ok;
  logic               shift_op;
  logic [NUM_OPS-1:0] cand;
  logic [31:0]        b_sel;
  logic               unused_fields;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign funct7  = instr[31:25];
  assign is_r    = (opcode == OP_RTYPE);
  assign f7_base = (funct7 == F7_BASE);
  assign f7_alt  = (funct7 == F7_ALT);
  assign unused_fields = ^{instr[24:15], instr[11:7]};

`ifdef ALU_ITYPE_EN
  assign is_i  = (opcode == OP_ITYPE);
  assign b_sel = is_i ? {{20{instr[31]}}, instr[31:20]} : rs2_data;
`else
  assign is_i  = 1'b0;
  assign b_sel = rs2_data;
`endif

  // For I-type, instr[31:25] is immediate, so funct7 only constrains the shifts.
  always_comb begin
    cand     = '0;
    f7_ok    = 1'b0;
    shift_op = 1'b0;
    case (funct3)
      F3_ADD: begin
        if (is_r && f7_alt) cand[OP_SUB] = 1'b1;
        else                cand[OP_ADD] = 1'b1;
        f7_ok = is_i || f7_base || f7_alt;
      end
      F3_SLL: begin
        cand[OP_SLL] = 1'b1;
        f7_ok        = f7_base;
        shift_op     = 1'b1;
      end
      F3_SLT: begin
        cand[OP_SLT] = 1'b1;
        f7_ok        = is_i || f7_base;
      end
      F3_SLTU: begin
        cand[OP_SLTU] = 1'b1;
        f7_ok         = is_i || f7_base;
      end
      F3_XOR: begin
        cand[OP_XOR] = 1'b1;
        f7_ok        = is_i || f7_base;
      end
      F3_SR: begin
        if (f7_alt) cand[OP_SRA] = 1'b1;
        else        cand[OP_SRL] = 1'b1;
        f7_ok    = f7_base || f7_alt;
        shift_op = 1'b1;
      end
      F3_OR: begin
        cand[OP_OR] = 1'b1;
        f7_ok       = is_i || f7_base;
      end
      F3_AND: begin
        cand[OP_AND] = 1'b1;
        f7_ok        = is_i || f7_base;
      end
      default: ;
    endcase

    op_en   = '0;
    illegal = 1'b1;
    opb     = rs2_data;
    if ((is_r || is_i) && f7_ok) begin
      op_en   = cand;
      illegal = 1'b0;
      opb     = shift_op ? {27'b0, b_sel[4:0]} : b_sel;
    end
  end

endmodule

// File: rtl/alu_op_issue.sv
// Decode-and-issue stage: decodes on the input side and issues through a 2-entry skid buffer.
// Build macro ALU_ITYPE_EN enables I-type ALU decoding inside alu_op_dec.
module alu_op_issue #(
  parameter int XLEN    = 32,
  parameter int NUM_OPS = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_instr,
  input  logic [XLEN-1:0]    in_rs1_data,
  input  logic [XLEN-1:0]    in_rs2_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OPS-1:0] out_op_en,
  output logic [XLEN-1:0]    out_rs1_data,
  output logic [XLEN-1:0]    out_rs2_data,
  output logic [4:0]         out_rd_addr,
  output logic               out_illegal
);
  import alu_pkg::*;

  // Handshake: a side transfers on any rising edge where its valid and ready are both 1.
  // in_ready is a flop equal to !skid_valid, so no combinational path reaches it.

  logic [NUM_OPS-1:0] dec_op_en;
  logic [XLEN-1:0]    dec_opb;
  logic               dec_illegal;
  issue_t             dec_entry;

  issue_t main_q, main_d, skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   in_fire, out_fire;

  alu_op_dec u_dec (
    .instr    (in_instr),
    .rs2_data (in_rs2_data),
    .op_en    (dec_op_en),
    .opb      (dec_opb),
    .illegal  (dec_illegal)
  );

  always_comb begin
    dec_entry.op_en   = dec_op_en;
    dec_entry.rs1     = in_rs1_data;
    dec_entry.rs2     = dec_opb;
    dec_entry.rd      = in_instr[11:7];
    dec_entry.illegal = dec_illegal;
  end

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = main_valid_q && out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q) begin
      // skid is never occupied while main is empty
      if (in_fire) begin
        main_d       = dec_entry;
        main_valid_d = 1'b1;
      end
    end else if (out_fire) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_d = dec_entry;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d       = dec_entry;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = main_valid_q;
  assign out_op_en    = main_q.op_en;
  assign out_rs1_data = main_q.rs1;
  assign out_rs2_data = main_q.rs2;
  assign out_rd_addr  = main_q.rd;
  assign out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed self-checking bench for alu_op_issue (honours ALU_ITYPE_EN when defined).
module tb_alu_op_issue;

  localparam logic [31:0] I_ADD = 32'h002081B3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_rs1_data = '0;
  logic [31:0] in_rs2_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [9:0]  out_op_en;
  logic [31:0] out_rs1_data;
  logic [31:0] out_rs2_data;
  logic [4:0]  out_rd_addr;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] rs2;
    logic [9:0]  op_en;
    logic [31:0] b;
    logic        ill;
  } vec_t;

  alu_op_issue dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_rs1_data  (in_rs1_data),
    .in_rs2_data  (in_rs2_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_op_en    (out_op_en),
    .out_rs1_data (out_rs1_data),
    .out_rs2_data (out_rs2_data),
    .out_rd_addr  (out_rd_addr),
    .out_illegal  (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
    in_valid    = 1'b1;
    in_instr    = instr;
    in_rs1_data = a;
    in_rs2_data = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_illegal !== 1'b0 || out_op_en !== 10'h000) begin
      errors++;
      $display("FAIL reset_ctrl out_valid=%b in_ready=%b illegal=%b op_en=%h want 0/1/0/000",
               out_valid, in_ready, out_illegal, out_op_en);
    end
    checks++;
    if (out_rs1_data !== 32'h0 || out_rs2_data !== 32'h0 || out_rd_addr !== 5'd0) begin
      errors++;
      $display("FAIL reset_data a=%h b=%h rd=%0d want 0/0/0", out_rs1_data, out_rs2_data, out_rd_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_add();
    @(negedge clk);
    out_ready = 1'b1;
    drive(I_ADD, 32'd5, 32'd7);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_op_en !== 10'h001 || out_illegal !== 1'b0) begin
      errors++;
      $display("FAIL add_ctrl valid=%b op_en=%h ill=%b want 1/001/0", out_valid, out_op_en, out_illegal);
    end
    checks++;
    if (out_rs1_data !== 32'd5 || out_rs2_data !== 32'd7 || out_rd_addr !== 5'd3) begin
      errors++;
      $display("FAIL add_data a=%h b=%h rd=%0d want 5/7/3", out_rs1_data, out_rs2_data, out_rd_addr);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_drain out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_decode();
    vec_t vecs[$];
    logic [31:0] a;
    logic [31:0] ins;
    vecs.push_back('{"sub",      32'h402081B3, 32'h00000007, 10'h002, 32'h00000007, 1'b0});
    vecs.push_back('{"sra",      32'h4020D1B3, 32'hFFFFFF23, 10'h100, 32'h00000003, 1'b0});
    vecs.push_back('{"srl",      32'h0020D1B3, 32'hFFFFFF25, 10'h080, 32'h00000005, 1'b0});
    vecs.push_back('{"sll",      32'h002091B3, 32'h0000003F, 10'h020, 32'h0000001F, 1'b0});
    vecs.push_back('{"xor",      32'h0020C1B3, 32'h12345678, 10'h004, 32'h12345678, 1'b0});
    vecs.push_back('{"or",       32'h0020E1B3, 32'h0000F0F0, 10'h008, 32'h0000F0F0, 1'b0});
    vecs.push_back('{"and",      32'h0020F1B3, 32'hCAFEBABE, 10'h010, 32'hCAFEBABE, 1'b0});
    vecs.push_back('{"sltu",     32'h0020B1B3, 32'h80000000, 10'h040, 32'h80000000, 1'b0});
    vecs.push_back('{"slt",      32'h0020A1B3, 32'hFFFFFFFF, 10'h200, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{"ill_f7",   32'h022081B3, 32'hFFFFFF23, 10'h000, 32'hFFFFFF23, 1'b1});
    vecs.push_back('{"ill_sr",   32'h6020D1B3, 32'hFFFFFF23, 10'h000, 32'hFFFFFF23, 1'b1});
    vecs.push_back('{"ill_xor",  32'h4020C1B3, 32'h00000009, 10'h000, 32'h00000009, 1'b1});
    vecs.push_back('{"ill_load", 32'h00208183, 32'h00000011, 10'h000, 32'h00000011, 1'b1});
`ifdef ALU_ITYPE_EN
    vecs.push_back('{"addi",     32'hFFF00093, 32'h00000055, 10'h001, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{"srai",     32'h4030D093, 32'h00000055, 10'h100, 32'h00000003, 1'b0});
`else
    vecs.push_back('{"addi",     32'hFFF00093, 32'h00000055, 10'h000, 32'h00000055, 1'b1});
    vecs.push_back('{"srai",     32'h4030D093, 32'h00000055, 10'h000, 32'h00000055, 1'b1});
`endif
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      a   = 32'h1000 + 32'(i);
      ins = vecs[i].instr;
      @(negedge clk);
      drive(ins, a, vecs[i].rs2);
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_op_en !== vecs[i].op_en || out_illegal !== vecs[i].ill) begin
        errors++;
        $display("FAIL dec_%s valid=%b op_en=%h ill=%b want 1/%h/%b", vecs[i].name,
                 out_valid, out_op_en, out_illegal, vecs[i].op_en, vecs[i].ill);
      end
      checks++;
      if (out_rs1_data !== a || out_rs2_data !== vecs[i].b || out_rd_addr !== ins[11:7]) begin
        errors++;
        $display("FAIL dec_%s_data a=%h b=%h rd=%0d want %h/%h/%0d", vecs[i].name,
                 out_rs1_data, out_rs2_data, out_rd_addr, a, vecs[i].b, ins[11:7]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_q.delete();
    out_ready = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k > 0) begin
        checks++;
        if (out_valid !== 1'b1 || exp_q.size() == 0 || out_rs1_data !== exp_q[0]) begin
          errors++;
          $display("FAIL b2b_out k=%0d valid=%b a=%h want 1/%h", k, out_valid, out_rs1_data,
                   (exp_q.size() > 0) ? exp_q[0] : 32'hX);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready k=%0d in_ready=%b want 1", k, in_ready);
        end
      end
      if (k < 5) begin
        drive(I_ADD, 32'h200 + 32'(k), 32'h1);
        exp_q.push_back(32'h200 + 32'(k));
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int got = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 6);
      if (cyc >= 2 && cyc < 6) begin
        checks++;
        if (in_ready !== 1'b0 || sent != 2) begin
          errors++;
          $display("FAIL bp_full cyc=%0d in_ready=%b sent=%0d want 0/2", cyc, in_ready, sent);
        end
        checks++;
        if (out_valid !== 1'b1 || out_rs1_data !== 32'h100) begin
          errors++;
          $display("FAIL bp_hold cyc=%0d valid=%b a=%h want 1/00000100", cyc, out_valid, out_rs1_data);
        end
      end
      if (got >= 1 && got < 4) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++;
          $display("FAIL bp_gap got=%0d out_valid=%b want 1", got, out_valid);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0 || out_rs1_data !== exp_q[0]) begin
          errors++;
          $display("FAIL bp_order got=%0d a=%h want %h", got, out_rs1_data,
                   (exp_q.size() > 0) ? exp_q[0] : 32'hX);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        got++;
      end
      if (sent < 4) drive(I_ADD, 32'h100 + 32'(sent), 32'h2);
      else          in_valid = 1'b0;
      if (in_valid && in_ready) begin
        exp_q.push_back(in_rs1_data);
        sent++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_count got=%0d left=%0d want 4/0", got, exp_q.size());
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    @(negedge clk);
    drive(I_ADD, 32'hA0, 32'h0);
    @(negedge clk);
    drive(I_ADD, 32'hB0, 32'h0);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_prefill in_ready=%b want 0", in_ready);
    end
    flush = 1'b1;
    drive(I_ADD, 32'hC0, 32'h0);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_full valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    drive(I_ADD, 32'hD0, 32'h0);
    @(negedge clk);
    flush = 1'b1;
    drive(I_ADD, 32'hE0, 32'h0);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_accept valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_ghost k=%0d valid=%b a=%h want 0", k, out_valid, out_rs1_data);
      end
    end
    drive(I_ADD, 32'hF0, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_rs1_data !== 32'hF0) begin
      errors++;
      $display("FAIL flush_resume valid=%b a=%h want 1/000000f0", out_valid, out_rs1_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    @(negedge clk);
    drive(I_ADD, 32'h55, 32'h0);
    @(negedge clk);
    drive(I_ADD, 32'h66, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_op_en !== 10'h000 || out_rs1_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_async valid=%b in_ready=%b op_en=%h a=%h want 0/1/000/0",
               out_valid, in_ready, out_op_en, out_rs1_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(I_ADD, 32'h77, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_rs1_data !== 32'h77) begin
      errors++;
      $display("FAIL rst_first valid=%b a=%h want 1/00000077", out_valid, out_rs1_data);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_drain valid=%b want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_decode();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_issue.md
# alu_op_issue

Registered decode-and-issue stage directly upstream of the integer ALU op units. Accepts a 32-bit RV32I instruction plus register-file operands over a valid/ready handshake, decodes R-type (and optionally I-type) ALU instructions into a one-hot operation-enable vector with the final operand pair, and presents them to the ALU through a 2-entry skid buffer. Throughput is one instruction per cycle with no combinational ready path.

## Interface
Parameters:
- XLEN, 32, operand and instruction width; only 32 is supported.
- NUM_OPS, 10, width of the one-hot enable vector.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous flush; drops all buffered entries.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept; driven directly from a register.
- in_instr  in  32  raw instruction.
- in_rs1_data  in  32  rs1 register value.
- in_rs2_data  in  32  rs2 register value.
- out_valid  out  1  issued op valid.
- out_ready  in  1  ALU/writeback accepts.
- out_op_en  out  10  one-hot: [0]add [1]sub [2]xor [3]or [4]and [5]sll [6]sltu [7]srl [8]sra [9]slt.
- out_rs1_data  out  32  operand A.
- out_rs2_data  out  32  operand B: rs2, or immediate; shift amounts are zero-extended to 32 bits from 5 bits.
- out_rd_addr  out  5  destination register, instr[11:7].
- out_illegal  out  1  instruction is not a supported ALU op.

## Operation
- R-type, opcode 0110011, is decoded on funct3/funct7:
  - funct3 000 gives add (funct7 0000000) or sub (funct7 0100000).
  - funct3 001 sll, 010 slt, 011 sltu, 100 xor, 110 or, 111 and; each requires funct7 0000000.
  - funct3 101 gives srl (funct7 0000000) or sra (funct7 0100000).
- Any other funct7, or any other opcode, sets out_illegal=1 and out_op_en=0. Operands and rd still pass through.
- Shift ops: out_rs2_data = {27'b0, B[4:0]}.
- A transfer occurs on any cycle where valid and ready are both high on that side.
- Skid buffer:
  - Main register holds the presented entry; skid register catches an accept that coincides with a stall (out_valid & !out_ready).
  - When out_ready returns, the skid entry moves to the main register in the same cycle.
  - in_ready = !skid_valid.
- Ordering is strict FIFO; no entry is dropped or duplicated except by flush.

## Timing
- Latency is 1 cycle from an in_valid&in_ready edge to out_valid, when the stage is empty.
- Back-to-back, one op per cycle while out_ready=1.
- Reset values:
  - out_valid=0, in_ready=1, out_illegal=0, out_op_en=0.
  - out_rs1_data, out_rs2_data and out_rd_addr all 0; skid_valid=0.
- Full (skid_valid=1): in_ready=0 on the next cycle. Any in_valid is ignored until the skid drains.
- Simultaneous out-accept and in-accept with the skid empty: the main register is replaced by the new entry, and the skid stays empty.
- Simultaneous out-accept with skid_valid=1: the skid moves to main, and in_ready rises the following cycle.
- flush=1 has priority over every accept:
  - Next cycle, out_valid=0, skid_valid=0 and in_ready=1.
  - An in-accept in the flush cycle is discarded.
- rst_n assertion mid-transfer clears everything asynchronously. The first accept is possible on the first edge after deassertion.
- out_* holds stable while out_valid=1 and out_ready=0.

## Configuration
- ALU_ITYPE_EN:
  - Defined:
    - Opcode 0010011 is decoded: addi, slti, sltiu, xori, ori, andi, slli, srli, srai.
    - Operand B is the sign-extended instr[31:20]; shifts use instr[24:20].
    - slli and srli require instr[31:25]=0000000; srai requires 0100000; anything else is illegal.
    - funct3 000 is always add (no subi).
  - Undefined: opcode 0010011 is illegal, and operand B is always rs2.

## Structure
- Package alu_pkg holds:
  - opcode constants (OP_RTYPE, OP_ITYPE);
  - funct3/funct7 constants;
  - one-hot bit indices (OP_ADD..OP_SLT);
  - NUM_OPS and XLEN.
- Sub-module alu_op_dec: purely combinational instruction-to-{op_en, operand B, illegal} decoder.
- The top instantiates alu_op_dec once on the input side and holds the main and skid registers plus handshake control.

## Test plan
- Reset, then a single add: instr 0x002081B3 (add x3,x1,x2), rs1=5, rs2=7, out_ready=1. Expect:
  - out_valid the next cycle;
  - out_op_en=0x001, A=5, B=7, rd=3, illegal=0.
- sub/sra funct7 selection:
  - 0x402081B3 gives op_en=0x002.
  - 0x4020D1B3 with rs2=0xFFFFFF23 gives op_en=0x100 and B=0x00000003.
- Illegal: funct7 0x01 on an R-type (0x022081B3), or opcode 0x03, gives illegal=1 and op_en=0; the handshake proceeds normally.
- Backpressure: stream 4 ops with out_ready held 0. Expect:
  - in_ready drops after 2 accepts;
  - releasing out_ready delivers all 4 in order with no gap once the stream resumes.
- Flush while full: flush=1 with in_valid=1 gives out_valid=0 and in_ready=1 next cycle, and the in-flight input is absent at the output.
- I-type (ALU_ITYPE_EN defined): addi x1,x0,-1 (0xFFF00093) gives op_en=0x001 and B=0xFFFFFFFF. Undefined: illegal=1.
